axi_wr_port_arbiter: RTL and testbench

- Shares the single AXI write port of the banked multi-read-port memory between NUM_REQ requesters (e.g. host loader, DMA, accelerator writeback).
- Grants one requester at a time with round-robin priority.
- Drives the full AW/W/B sequence for the granted burst: generates WLAST from its own beat counter, holds W_EN for the whole transaction, and returns per-requester completion and error status.
- Sits between the requesters and the memory write channels; the read channels bypass it.

---
 rtl/axi_wr_port_arbiter_if.sv | 30 +++
 rtl/axi_wr_port_arbiter.sv | 122 ++++++++++++
 tb/tb_axi_wr_port_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_wr_port_arbiter_if.sv
// Memory-side AXI write port (AW/W/B plus the write enable) shared by all requesters.
// The arbiter drives it through the master modport; the memory sits on the slave modport.
interface axi_wr_port_arbiter_if #(
    parameter int W_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH   = 32
);
    logic                    W_EN;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [W_ADDR_WIDTH-1:0] AWADDR;
    logic                    AWBURST;
    logic [7:0]              AWLEN;
    logic                    WVALID;
    logic                    WREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic                    WLAST;
    logic                    BVALID;
    logic                    BREADY;
    logic [1:0]              BRESP;

    modport master (
        output W_EN, AWVALID, AWADDR, AWBURST, AWLEN, WVALID, WDATA, WLAST, BREADY,
        input  AWREADY, WREADY, BVALID, BRESP
    );

    modport slave (
        input  W_EN, AWVALID, AWADDR, AWBURST, AWLEN, WVALID, WDATA, WLAST, BREADY,
        output AWREADY, WREADY, BVALID, BRESP
    );
endinterface

// File: rtl/axi_wr_port_arbiter.sv
// Round-robin arbiter that gives one requester at a time the memory's single AXI write port
// and runs the full AW/W/B sequence for that requester's burst.
module axi_wr_port_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int W_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                                   ACLK,
    input  logic                                   ARESETn,
    input  logic [NUM_REQ-1:0]                     req_valid,
    input  logic [NUM_REQ-1:0][W_ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ-1:0][7:0]                req_len,
    input  logic [NUM_REQ-1:0]                     req_burst,
    output logic [NUM_REQ-1:0]                     req_ready,
    input  logic [NUM_REQ-1:0]                     req_wvalid,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     req_wdata,
    output logic [NUM_REQ-1:0]                     req_wready,
    output logic [NUM_REQ-1:0]                     req_done,
    output logic                                   req_err,
    axi_wr_port_arbiter_if.master                  mem
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        rr_ptr, grant_q, pick_idx;
    logic                    pick_ok;
    logic [W_ADDR_WIDTH-1:0] addr_q;
    logic [7:0]              len_q, beat_cnt;
    logic                    burst_q;
    logic [NUM_REQ-1:0]      ready_q, done_q, grant_oh;
    logic                    err_q;
    logic                    in_data, w_hs, last_beat;

    // Cyclic search from rr_ptr: walk from the far end back so the nearest hit wins.
    always_comb begin
        pick_idx = '0;
        pick_ok  = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[IDX_W'((int'(rr_ptr) + k) % NUM_REQ)]) begin
                pick_idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
                pick_ok  = 1'b1;
            end
        end
    end

    assign grant_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
    assign in_data   = (state_q == DATA);
    assign last_beat = (beat_cnt == len_q);
    assign w_hs      = in_data && req_wvalid[grant_q] && mem.WREADY;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_ok)               state_d = ADDR;
            ADDR:    if (mem.AWREADY)           state_d = DATA;
            DATA:    if (w_hs && last_beat)     state_d = RESP;
            RESP:    if (mem.BVALID)            state_d = IDLE;
            default:                            state_d = IDLE;
        endcase
    end

    // Request fields are captured once at grant; later changes on the requester side are ignored.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rr_ptr   <= '0;
            grant_q  <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            burst_q  <= 1'b0;
            beat_cnt <= '0;
            ready_q  <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            ready_q <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: if (pick_ok) begin
                    grant_q <= pick_idx;
                    addr_q  <= req_addr[pick_idx];
                    len_q   <= req_len[pick_idx];
                    burst_q <= req_burst[pick_idx];
                    ready_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                end
                DATA: if (w_hs) beat_cnt <= beat_cnt + 8'd1;
                RESP: if (mem.BVALID) begin
                    done_q   <= grant_oh;
                    err_q    <= (mem.BRESP == 2'b10);
                    rr_ptr   <= (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                    beat_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    assign req_ready   = ready_q;
    assign req_done    = done_q;
    assign req_err     = err_q;

    assign mem.W_EN    = (state_q != IDLE);
    assign mem.AWVALID = (state_q == ADDR);
    assign mem.AWADDR  = (state_q == ADDR) ? addr_q  : '0;
    assign mem.AWLEN   = (state_q == ADDR) ? len_q   : '0;
    assign mem.AWBURST = (state_q == ADDR) ? burst_q : 1'b0;
    assign mem.WVALID  = in_data && req_wvalid[grant_q];
    assign mem.WDATA   = in_data ? req_wdata[grant_q] : '0;
    assign mem.WLAST   = in_data && last_beat;
    assign mem.BREADY  = (state_q == RESP);

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_wready
        assign req_wready[i] = in_data && (grant_q == IDX_W'(i)) && mem.WREADY;
    end
endmodule

// File: tb/tb_axi_wr_port_arbiter.sv
// Directed + randomized bench for axi_wr_port_arbiter; a round-robin model predicts each grant.
module tb_axi_wr_port_arbiter;
    localparam int N = 2, AW = 10, DW = 32;

    logic                    ACLK = 1'b0;
    logic                    ARESETn;
    logic [N-1:0]            req_valid, req_burst, req_wvalid;
    logic [N-1:0]            req_ready, req_wready, req_done;
    logic [N-1:0][AW-1:0]    req_addr;
    logic [N-1:0][7:0]       req_len;
    logic [N-1:0][DW-1:0]    req_wdata;
    logic                    req_err;

    axi_wr_port_arbiter_if #(.W_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem ();

    axi_wr_port_arbiter #(.NUM_REQ(N), .W_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_burst(req_burst),
        .req_ready(req_ready), .req_wvalid(req_wvalid), .req_wdata(req_wdata),
        .req_wready(req_wready), .req_done(req_done), .req_err(req_err), .mem(mem)
    );

    always #5 ACLK = ~ACLK;

    int n_chk = 0, n_err = 0;
    int model_rr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] m, input int rr);
        for (int k = 0; k < N; k++) if (m[(rr + k) % N]) return (rr + k) % N;
        return -1;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"},   req_ready,   '0);
        chk({tag, "_wready"},  req_wready,  '0);
        chk({tag, "_done"},    req_done,    '0);
        chk({tag, "_err"},     req_err,     '0);
        chk({tag, "_wen"},     mem.W_EN,    '0);
        chk({tag, "_awvalid"}, mem.AWVALID, '0);
        chk({tag, "_awaddr"},  mem.AWADDR,  '0);
        chk({tag, "_awburst"}, mem.AWBURST, '0);
        chk({tag, "_awlen"},   mem.AWLEN,   '0);
        chk({tag, "_wvalid"},  mem.WVALID,  '0);
        chk({tag, "_wdata"},   mem.WDATA,   '0);
        chk({tag, "_wlast"},   mem.WLAST,   '0);
        chk({tag, "_bready"},  mem.BREADY,  '0);
    endtask

    // One full transaction, entered and left on a negedge. abort_at >= 0 resets the DUT at that beat.
    task automatic burst(input logic [N-1:0] vmask, input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic bt, input logic [1:0] bresp, input bit hold,
                         input int stall_at, input int abort_at, input bit rnd);
        int g, cyc, b, stall, guard, d;
        bit stalled, wv, wr;
        logic [N-1:0] oh;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] wd;
        for (int i = 0; i < N; i++) begin
            req_addr[i]  = addr + AW'(i * 7);
            req_len[i]   = len;
            req_burst[i] = bt;
        end
        req_valid = vmask;
        g  = pick(vmask, model_rr);
        oh = N'(1) << g;
        e_addr = addr + AW'(g * 7);
        cyc = 0;
        do begin
            @(negedge ACLK);
            cyc++;
        end while (req_ready == '0 && cyc < 4);
        chk("grant_latency", cyc, 1);
        chk("grant_onehot", req_ready, oh);
        chk("done_pulse_cleared", req_done, '0);
        if (req_ready == '0) return;
        chk("aw_valid", mem.AWVALID, 1);
        chk("aw_addr", mem.AWADDR, e_addr);
        chk("aw_len", mem.AWLEN, len);
        chk("aw_burst", mem.AWBURST, bt);
        chk("aw_wen", mem.W_EN, 1);
        if (!hold) req_valid[g] = 1'b0;
        req_addr[g] = ~e_addr;
        req_len[g]  = ~len;
        req_burst[g] = ~bt;
        d = rnd ? $urandom_range(0, 3) : 0;
        for (int i = 0; i < d; i++) begin
            @(negedge ACLK);
            chk("aw_hold", mem.AWVALID, 1);
        end
        mem.AWREADY = 1'b1;
        @(negedge ACLK);
        mem.AWREADY = 1'b0;
        chk("aw_drop", mem.AWVALID, 0);
        b = 0; stall = 0; stalled = 0; guard = 0;
        while (b <= int'(len) && guard < 3000) begin
            guard++;
            if (b == abort_at) begin
                req_wvalid = '1;
                mem.WREADY = 1'b1;
                #2 ARESETn = 1'b0;
                #1 chk_all_zero("abort");
                req_valid = '0; req_wvalid = '0; mem.WREADY = 1'b0;
                @(negedge ACLK);
                @(negedge ACLK);
                chk("abort_no_done", req_done, '0);
                ARESETn = 1'b1;
                model_rr = 0;
                return;
            end
            if (b == stall_at && !stalled) begin stall = 5; stalled = 1; end
            wv = (stall > 0) ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            if (stall > 0) stall--;
            wr = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            wd = $urandom;
            for (int i = 0; i < N; i++) req_wdata[i] = ~wd;
            req_wvalid    = ~oh;
            req_wvalid[g] = wv;
            req_wdata[g]  = wd;
            mem.WREADY    = wr;
            #1;
            chk("w_valid", mem.WVALID, wv);
            if (wv) chk("w_data", mem.WDATA, wd);
            chk("w_last", mem.WLAST, (b == int'(len)));
            chk("w_ready_route", req_wready, wr ? oh : '0);
            if (wv && wr) b++;
            @(negedge ACLK);
        end
        if (guard >= 3000) chk("data_timeout", guard, 0);
        req_wvalid = '0;
        mem.WREADY = 1'b0;
        chk("b_ready", mem.BREADY, 1);
        chk("b_no_extra_beat", mem.WVALID, 0);
        d = rnd ? $urandom_range(0, 3) : 0;
        for (int i = 0; i < d; i++) begin
            @(negedge ACLK);
            chk("b_hold", mem.BREADY, 1);
        end
        mem.BVALID = 1'b1;
        mem.BRESP  = bresp;
        @(negedge ACLK);
        mem.BVALID = 1'b0;
        mem.BRESP  = 2'b00;
        chk("done", req_done, oh);
        chk("err", req_err, (bresp == 2'b10));
        chk("idle_wen", mem.W_EN, 0);
        model_rr = (g + 1) % N;
    endtask

    initial begin
        ARESETn = 1'b0;
        req_valid = '1; req_addr = '0; req_len = '0; req_burst = '0;
        req_wvalid = '1; req_wdata = '1;
        mem.AWREADY = 1'b0; mem.WREADY = 1'b1; mem.BVALID = 1'b0; mem.BRESP = 2'b00;
        repeat (3) @(negedge ACLK);
        chk_all_zero("reset");
        req_valid = '0; req_wvalid = '0; mem.WREADY = 1'b0;
        ARESETn = 1'b1;
        @(negedge ACLK);

        // simultaneous requests after reset: 0 then 1
        burst(2'b11, 10'h100, 8'd2, 1'b1, 2'b00, 0, -1, -1, 0);
        burst(2'b10, 10'h140, 8'd1, 1'b1, 2'b00, 0, -1, -1, 0);
        // single requester 0, AWLEN=3, OKAY-ish response
        burst(2'b01, 10'h020, 8'd3, 1'b1, 2'b01, 0, -1, -1, 0);
        // both held high: grants alternate 1,0,1
        burst(2'b11, 10'h200, 8'd1, 1'b1, 2'b00, 1, -1, -1, 0);
        burst(2'b11, 10'h210, 8'd2, 1'b0, 2'b00, 1, -1, -1, 0);
        burst(2'b11, 10'h220, 8'd0, 1'b1, 2'b00, 1, -1, -1, 0);
        // len=0 FIXED, error path, stalled data, longest burst
        burst(2'b01, 10'h055, 8'd0, 1'b0, 2'b00, 0, -1, -1, 0);
        burst(2'b10, 10'h3FE, 8'd7, 1'b1, 2'b10, 0, -1, -1, 0);
        burst(2'b01, 10'h080, 8'd3, 1'b1, 2'b00, 0, 1, -1, 0);
        burst(2'b10, 10'h000, 8'd255, 1'b1, 2'b00, 0, -1, -1, 0);

        for (int r = 0; r < 20; r++) begin
            burst(N'($urandom_range(1, (1 << N) - 1)), AW'($urandom), 8'($urandom_range(0, 15)),
                  1'($urandom), 2'($urandom), 1'($urandom_range(0, 1)), -1, -1, 1);
        end

        // leave rr pointing at 1, then abort a burst and confirm the pointer restarts at 0
        burst(2'b01, 10'h111, 8'd1, 1'b1, 2'b00, 0, -1, -1, 0);
        burst(2'b01, 10'h123, 8'd5, 1'b1, 2'b00, 0, -1, 2, 0);
        @(negedge ACLK);
        burst(2'b11, 10'h130, 8'd1, 1'b1, 2'b00, 0, -1, -1, 0);
        burst(2'b10, 10'h2A0, 8'd3, 1'b1, 2'b01, 0, -1, -1, 0);

        req_valid = '0;
        repeat (2) @(negedge ACLK);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
